// File: rtl/key_cond_pkg.sv
// Shared types and default 50 MHz timing constants for the pushbutton conditioner.
package key_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_t;

    localparam int DEF_DB_CYCLES     = 500000;    // 10 ms at 50 MHz
    localparam int DEF_REPEAT_DELAY  = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD = 5000000;   // 100 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Single-key synchronizer, debounce FSM, press/release pulses and 8-bit press counter.
// Auto-repeat while held is built only when KEY_REPEAT_EN is defined.
module key_debounce_fsm
    import key_cond_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic [7:0] press_count
);

`ifdef KEY_REPEAT_EN
    localparam int MAX_CYC = max_int(DB_CYCLES, max_int(REPEAT_DELAY, REPEAT_PERIOD));
`else
    localparam int MAX_CYC = DB_CYCLES;
`endif
    localparam int CW = $clog2(MAX_CYC);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
`endif

    logic [1:0]    sync_q, sync_d;
    key_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [7:0]    count_q, count_d;
    logic          s;
`ifdef KEY_REPEAT_EN
    logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_first_q, rpt_first_d;
`endif

    // s is the metastability-filtered copy; 0 means the button is down
    assign s = sync_q[1];

    always_comb begin
        sync_d    = {sync_q[0], key_n};
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
`ifdef KEY_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
`endif
        case (state_q)
            RELEASED: begin
                if (!s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
`ifdef KEY_REPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
`ifdef KEY_REPEAT_EN
                    rpt_cnt_d = '0;
`endif
                end else begin
`ifdef KEY_REPEAT_EN
                    // first repeat waits the long delay, later ones the short period
                    if (rpt_cnt_q == (rpt_first_q ? DELAY_LAST : PERIOD_LAST)) begin
                        rpt_cnt_d   = '0;
                        rpt_first_d = 1'b0;
                        press_d     = 1'b1;
                        count_d     = count_q + 8'd1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                if (!s) begin
                    // bounce back: level never dropped, so no new press is reported
                    state_d = PRESSED;
                    cnt_d   = '0;
`ifdef KEY_REPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
`endif
                end else if (cnt_q == DB_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
`ifdef KEY_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
`ifdef KEY_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign press_count = count_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low pushbutton vector: one independent debouncer per key.
// Define KEY_REPEAT_EN to add auto-repeat press pulses while a key is held.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS      = 2,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                  max10_clk1_50,
    input  logic                  reset_n,
    input  logic [NUM_KEYS-1:0]   key_n,
    output logic [NUM_KEYS-1:0]   key_level,
    output logic [NUM_KEYS-1:0]   key_press,
    output logic [NUM_KEYS-1:0]   key_release,
    output logic [8*NUM_KEYS-1:0] press_count
);

    // REPEAT_* are validated even when repeat is compiled out so a bad override is still caught
    if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_conditioner: illegal timing parameters");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_fsm #(
            .DB_CYCLES     (DB_CYCLES)
`ifdef KEY_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_fsm (
            .clk         (max10_clk1_50),
            .rst_n       (reset_n),
            .key_n       (key_n[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .press_count (press_count[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner against a run-length debounce reference model.
module tb_key_conditioner;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] key_level, key_press, key_release;
    logic [8*NK-1:0] press_count;

    key_conditioner #(
        .NUM_KEYS      (NK),
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .max10_clk1_50 (clk),
        .reset_n       (reset_n),
        .key_n         (key_n),
        .key_level     (key_level),
        .key_press     (key_press),
        .key_release   (key_release),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the debouncer sees key_n two edges late; a level change is
    // accepted once DB+1 consecutive edges disagree with the current level.
    logic [NK-1:0] m_sa, m_sb, m_s, m_level, m_press, m_release;
    int            m_run  [NK];
    logic [7:0]    m_cnt  [NK];
    int            m_hold [NK];
    int            m_thr  [NK];
    int            edge_no;

    logic [21:0] dut_all, m_all;
    assign dut_all = {key_level, key_press, key_release, press_count};
    assign m_all   = {m_level, m_press, m_release, m_cnt[1], m_cnt[0]};

    task automatic model_reset();
        m_sa = '1; m_sb = '1; m_s = '1;
        m_level = '0; m_press = '0; m_release = '0;
        edge_no = -1;
        for (int i = 0; i < NK; i++) begin
            m_run[i] = 0; m_cnt[i] = 8'd0; m_hold[i] = 0; m_thr[i] = RD;
        end
    endtask

    task automatic model_step();
        edge_no++;
        m_s  = m_sb;
        m_sb = m_sa;
        m_sa = key_n;
        m_press = '0;
        m_release = '0;
        for (int i = 0; i < NK; i++) begin
            if (!m_s[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DB + 1) begin
                    m_run[i] = 0;
                    m_level[i] = !m_s[i];
                    if (m_level[i]) begin
                        m_press[i] = 1'b1;
                        m_cnt[i] = m_cnt[i] + 8'd1;
                        m_hold[i] = 0;
                        m_thr[i] = RD;
                    end else begin
                        m_release[i] = 1'b1;
                    end
                end
            end else begin
                if (REP_EN && m_level[i]) begin
                    if (m_run[i] != 0) begin
                        m_hold[i] = 0;
                        m_thr[i] = RP;
                    end else begin
                        m_hold[i]++;
                        if (m_hold[i] == m_thr[i]) begin
                            m_hold[i] = 0;
                            m_thr[i] = RP;
                            m_press[i] = 1'b1;
                            m_cnt[i] = m_cnt[i] + 8'd1;
                        end
                    end
                end
                m_run[i] = 0;
            end
        end
    endtask

    // Advance one clock: model follows the DUT edge, then return at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset_n) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_n = 2'b00;
        repeat (3) tick();
        checks++;
        if (dut_all !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", dut_all);
        end
        reset_n = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            tick();
            checks++;
            if (key_press !== ((e == 6) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL reset_held_press edge %0d: got %b want %b", e, key_press, (e == 6) ? 2'b11 : 2'b00);
            end
            checks++;
            if (dut_all !== m_all) begin
                errors++;
                $display("FAIL reset_model edge %0d: got %h want %h", e, dut_all, m_all);
            end
        end
        checks++;
        if (press_count !== 16'h0101) begin
            errors++;
            $display("FAIL reset_count: got %h want 0101", press_count);
        end
    endtask

    task automatic test_clean_press();
        int k, t_ev, n_ev;
        key_n = 2'b11;
        repeat (12) tick();
        key_n[0] = 1'b0;
        k = edge_no + 1;
        t_ev = -1; n_ev = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (key_press[0]) begin n_ev++; if (t_ev < 0) t_ev = edge_no; end
            checks++;
            if (dut_all !== m_all) begin
                errors++;
                $display("FAIL clean_press_model: got %h want %h", dut_all, m_all);
            end
        end
        checks++;
        if (n_ev != 1 || t_ev != k + 6) begin
            errors++;
            $display("FAIL clean_press_timing: got %0d pulses at edge %0d want 1 at %0d", n_ev, t_ev, k + 6);
        end
        checks++;
        if (key_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL clean_press_level: got %b want 1", key_level[0]);
        end
        key_n[0] = 1'b1;
        k = edge_no + 1;
        t_ev = -1; n_ev = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (key_release[0]) begin n_ev++; if (t_ev < 0) t_ev = edge_no; end
            checks++;
            if (dut_all !== m_all) begin
                errors++;
                $display("FAIL clean_release_model: got %h want %h", dut_all, m_all);
            end
        end
        checks++;
        if (n_ev != 1 || t_ev != k + 6 || key_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_release_timing: got %0d pulses at edge %0d level %b want 1 at %0d level 0",
                     n_ev, t_ev, key_level[0], k + 6);
        end
    endtask

    task automatic test_glitch();
        int k, t_ev, n_ev;
        key_n = 2'b11;
        repeat (12) tick();
        key_n[1] = 1'b0;
        repeat (3) tick();
        key_n[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (key_press[1] !== 1'b0 || key_level[1] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_short: got press %b level %b want 0 0", key_press[1], key_level[1]);
            end
        end
        n_ev = 0;
        for (int c = 0; c < 12; c++) begin
            key_n[1] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            if (key_press[1]) n_ev++;
        end
        key_n[1] = 1'b0;
        k = edge_no + 1;
        t_ev = -1;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (key_press[1]) begin n_ev++; if (t_ev < 0) t_ev = edge_no; end
            checks++;
            if (dut_all !== m_all) begin
                errors++;
                $display("FAIL bounce_model: got %h want %h", dut_all, m_all);
            end
        end
        checks++;
        if (n_ev != 1 || t_ev != k + 6) begin
            errors++;
            $display("FAIL bounce_timing: got %0d pulses at edge %0d want 1 at %0d", n_ev, t_ev, k + 6);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] start0, start1;
        key_n = 2'b11;
        repeat (12) tick();
        start0 = m_cnt[0];
        start1 = m_cnt[1];
        for (int p = 0; p < 256; p++) begin
            key_n[0] = 1'b0;
            repeat (8) tick();
            key_n[0] = 1'b1;
            repeat (8) tick();
        end
        repeat (4) tick();
        checks++;
        if (press_count[7:0] !== start0 || press_count[15:8] !== start1) begin
            errors++;
            $display("FAIL wrap_count: got %h_%h want %h_%h",
                     press_count[15:8], press_count[7:0], start1, start0);
        end
        checks++;
        if (dut_all !== m_all) begin
            errors++;
            $display("FAIL wrap_model: got %h want %h", dut_all, m_all);
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 60; seg++) begin
            key_n = NK'($urandom);
            len = $urandom_range(10, 1);
            for (int c = 0; c < len; c++) begin
                tick();
                checks++;
                if (dut_all !== m_all) begin
                    errors++;
                    $display("FAIL random_model seg %0d: got %h want %h", seg, dut_all, m_all);
                end
            end
        end
    endtask

    task automatic test_hold_repeat();
        int k, a, o, n_exp;
        logic exp_p;
        logic [7:0] exp_cnt;
        key_n = 2'b11;
        repeat (14) tick();
        exp_cnt = m_cnt[0];
        key_n[0] = 1'b0;
        k = edge_no + 1;
        a = k + 6;
        n_exp = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            o = edge_no - a;
            exp_p = (o == 0) || (REP_EN && o >= RD && ((o - RD) % RP) == 0);
            if (exp_p) n_exp++;
            checks++;
            if (key_press[0] !== exp_p) begin
                errors++;
                $display("FAIL hold_press offset %0d: got %b want %b", o, key_press[0], exp_p);
            end
            if (o >= 30) break;
        end
        exp_cnt = exp_cnt + 8'(n_exp);
        checks++;
        if (press_count[7:0] !== exp_cnt) begin
            errors++;
            $display("FAIL hold_count: got %0d want %0d", press_count[7:0], exp_cnt);
        end
        key_n[0] = 1'b1;
        n_exp = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (key_release[0]) n_exp++;
        end
        checks++;
        if (n_exp != 1 || key_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got %0d pulses level %b want 1 level 0", n_exp, key_level[0]);
        end
    endtask

    task automatic test_reset_midop();
        int k;
        key_n = 2'b11;
        repeat (12) tick();
        key_n[0] = 1'b0;
        k = edge_no + 1;
        for (int c = 0; c < 10 && edge_no < k + 4; c++) tick();
        checks++;
        if (edge_no != k + 4) begin
            errors++;
            $display("FAIL midop_reach: got edge %0d want %0d", edge_no, k + 4);
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_all !== 22'd0) begin
            errors++;
            $display("FAIL midop_reset_state: got %h want 0", dut_all);
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (key_press[0] !== (edge_no == 6) || key_level[0] !== (edge_no >= 6)) begin
                errors++;
                $display("FAIL midop_restart edge %0d: got press %b level %b want %b %b",
                         edge_no, key_press[0], key_level[0], edge_no == 6, edge_no >= 6);
            end
            checks++;
            if (dut_all !== m_all) begin
                errors++;
                $display("FAIL midop_model: got %h want %h", dut_all, m_all);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_glitch();
        test_wrap();
        test_random();
        test_hold_repeat();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
